// File: rtl/cpe_weight_loader_pkg.sv
// Shared constants and FSM encoding for the compensation weight loader.
// The drain length is derived from the memory read latency.
package cpe_weight_loader_pkg;

  localparam int CPE_WEIGHT_WIDTH = 4;
  localparam int MEM_RD_LATENCY   = 1;
  localparam int OUT_REG_STAGES   = 1;
  // Cycles from the last read until its beat has been presented to the columns.
  localparam int DRAIN_CYCLES     = MEM_RD_LATENCY + OUT_REG_STAGES;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/cpe_weight_loader.sv
// Streams one compensation weight tile, farthest row first, into the tops of
// the CPE shift columns. It raises busy for the whole load and pulses done at the end.
module cpe_weight_loader
  import cpe_weight_loader_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  output logic                               mem_rd_en,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  input  logic [CPE_WEIGHT_WIDTH*COLS-1:0]   mem_rdata,
  output logic [CPE_WEIGHT_WIDTH*COLS-1:0]   comp_weight,
  output logic                               comp_weight_valid,
  output logic                               busy,
  output logic                               done
);

  localparam int K_W = $clog2(ROWS + 1);
  localparam int D_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [K_W-1:0]        ROWS_K    = K_W'(ROWS);
  localparam logic [D_W-1:0]        DRAIN_END = D_W'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] TOP_ROW   = ADDR_WIDTH'(ROWS - 1);

  state_t                    state;
  logic [ADDR_WIDTH-1:0]     base_q;
  logic [K_W-1:0]            k;
  logic [D_W-1:0]            drain_cnt;
  logic [MEM_RD_LATENCY-1:0] rd_pipe;

  // k counts rows already issued; the first read leaves on the accepting
  // edge so that the memory strobe and address come straight from flops.
  // NOTE: every sequential block uses non-blocking assignments so that all
  // flops sample their inputs from the same edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base_q    <= '0;
      k         <= '0;
      drain_cnt <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            k         <= K_W'(1);
            mem_rd_en <= 1'b1;
            mem_addr  <= base_addr + TOP_ROW;
            busy      <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          if (k == ROWS_K) begin
            mem_rd_en <= 1'b0;
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            // Address arithmetic wraps modulo 2^ADDR_WIDTH.
            mem_addr <= base_q + TOP_ROW - ADDR_WIDTH'(k);
            k        <= k + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_END) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the weight register is reset as well, because the columns see
  // comp_weight directly and an aborted load must leave the outputs at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe           <= '0;
      comp_weight       <= '0;
      comp_weight_valid <= 1'b0;
    end else begin
      rd_pipe           <= (rd_pipe << 1) | MEM_RD_LATENCY'(mem_rd_en);
      comp_weight_valid <= rd_pipe[MEM_RD_LATENCY-1];
      if (rd_pipe[MEM_RD_LATENCY-1]) begin
        comp_weight <= mem_rdata;
      end
    end
  end

endmodule
